// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC source
// encodings, FSM state encodings and default parameter values.
package pc_sequencer_pkg;

    localparam int unsigned DEF_AW        = 31;
    localparam int unsigned DEF_INC       = 4;
    localparam int unsigned DEF_ALIGN     = 2;
    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_ILLOP_VEC = 4;
    localparam int unsigned DEF_IRQ_VEC   = 8;

    localparam int unsigned PC_SEL_W = 2;
    localparam int unsigned STATE_W  = 2;

    // Next-PC source selected by the decode stage.
    typedef enum logic [PC_SEL_W-1:0] {
        PC_SEQ   = 2'b00,
        PC_BR    = 2'b01,
        PC_JMP   = 2'b10,
        PC_ILLOP = 2'b11
    } pc_sel_e;

    // Sequencer FSM states.
    typedef enum logic [STATE_W-1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch-stage control and the PC sequencer.
//   Stall, Halt, Resume, PcSel, BranchTarget, JumpTarget, IrqReq : towards sequencer
//   Pc, PcInc, PcValid, IrqTaken, XpValue, Halted                : from sequencer
// master = the side driving control, slave = the sequencer itself.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
);
    logic                  Stall;
    logic                  Halt;
    logic                  Resume;
    logic [PC_SEL_W-1:0]   PcSel;
    logic [AW-1:0]         BranchTarget;
    logic [AW:0]           JumpTarget;
    logic                  IrqReq;
    logic [AW:0]           Pc;
    logic [AW:0]           PcInc;
    logic                  PcValid;
    logic                  IrqTaken;
    logic [AW:0]           XpValue;
    logic                  Halted;

    modport master (
        output Stall, Halt, Resume, PcSel, BranchTarget, JumpTarget, IrqReq,
        input  Pc, PcInc, PcValid, IrqTaken, XpValue, Halted
    );

    modport slave (
        input  Stall, Halt, Resume, PcSel, BranchTarget, JumpTarget, IrqReq,
        output Pc, PcInc, PcValid, IrqTaken, XpValue, Halted
    );

endinterface

// File: rtl/pc_incrementer.sv
// Sequential-address adder: adds INC to the low AW address bits, wrapping
// modulo 2^AW, and passes the supervisor bit (bit AW) through untouched.
//   pc_i     : current PC including supervisor bit
//   pc_inc_c : pc_i + INC (combinational)
module pc_incrementer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned INC = DEF_INC
) (
    input  logic [AW:0] pc_i,
    output logic [AW:0] pc_inc_c
);

    // Carry out of the address field is dropped so it never flips privilege.
    assign pc_inc_c = {pc_i[AW], pc_i[AW-1:0] + AW'(INC)};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with supervisor bit. Chooses the next PC from
// sequential, branch, jump, illegal-op trap and interrupt trap sources and
// handles stall, halt/resume and a one-cycle boot state after reset.
//   Clock, Reset_n : clock and asynchronous active-low reset
//   bus (slave)    : control in (Stall/Halt/Resume/PcSel/targets/IrqReq),
//                    status out (Pc/PcInc/PcValid/IrqTaken/XpValue/Halted)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned INC       = DEF_INC,
    parameter int unsigned ALIGN     = DEF_ALIGN,
    parameter int unsigned RESET_VEC = DEF_RESET_VEC,
    parameter int unsigned ILLOP_VEC = DEF_ILLOP_VEC,
    parameter int unsigned IRQ_VEC   = DEF_IRQ_VEC
) (
    input  logic          Clock,
    input  logic          Reset_n,
    pc_sequencer_if.slave bus
);

    // Loaded targets have their low ALIGN bits cleared.
    localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << ALIGN;
    localparam logic [AW:0]   RESET_PC   = {1'b1, AW'(RESET_VEC) & ALIGN_MASK};
    localparam logic [AW:0]   ILLOP_PC   = {1'b1, AW'(ILLOP_VEC) & ALIGN_MASK};
    localparam logic [AW:0]   IRQ_PC     = {1'b1, AW'(IRQ_VEC) & ALIGN_MASK};

    state_e        state_q, state_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   xp_q, xp_d;
    logic          irq_pend_q, irq_pend_d;
    logic          irq_taken_q, irq_taken_d;
    logic          pc_valid_q, pc_valid_d;
    logic          halted_q, halted_d;
    logic [AW:0]   pc_inc_c;
    pc_sel_e       sel_c;

    assign sel_c = pc_sel_e'(bus.PcSel);

    pc_incrementer #(
        .AW  (AW),
        .INC (INC)
    ) u_inc (
        .pc_i     (pc_q),
        .pc_inc_c (pc_inc_c)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stall only blocks a halt request from RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!bus.Stall && bus.Halt) state_d = HALT;
            HALT:    if (bus.Resume) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Next PC, trap capture and interrupt bookkeeping.
    always_comb begin
        pc_d        = pc_q;
        xp_d        = xp_q;
        irq_taken_d = 1'b0;
        irq_pend_d  = irq_pend_q | (bus.IrqReq & (state_q != BOOT));
        pc_valid_d  = (state_d == RUN);
        halted_d    = (state_d == HALT);

        if (state_q == RUN && !bus.Stall) begin
            if (sel_c == PC_ILLOP) begin
                // Illegal op beats a pending interrupt, which stays pending.
                pc_d = ILLOP_PC;
                xp_d = pc_inc_c;
            end else if (irq_pend_q && !pc_q[AW]) begin
                // A request arriving in the trap cycle re-arms pending.
                pc_d        = IRQ_PC;
                xp_d        = pc_inc_c;
                irq_taken_d = 1'b1;
                irq_pend_d  = bus.IrqReq;
            end else begin
                case (sel_c)
                    // Jumps can drop but never raise the supervisor bit.
                    PC_JMP:  pc_d = {pc_q[AW] & bus.JumpTarget[AW],
                                     bus.JumpTarget[AW-1:0] & ALIGN_MASK};
                    PC_BR:   pc_d = {pc_q[AW], bus.BranchTarget & ALIGN_MASK};
                    default: pc_d = pc_inc_c;
                endcase
            end
        end
    end

    // Datapath and status registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q        <= RESET_PC;
            xp_q        <= '0;
            irq_pend_q  <= 1'b0;
            irq_taken_q <= 1'b0;
            pc_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            xp_q        <= xp_d;
            irq_pend_q  <= irq_pend_d;
            irq_taken_q <= irq_taken_d;
            pc_valid_q  <= pc_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.Pc       = pc_q;
    assign bus.PcInc    = pc_inc_c;
    assign bus.PcValid  = pc_valid_q;
    assign bus.IrqTaken = irq_taken_q;
    assign bus.XpValue  = xp_q;
    assign bus.Halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the PC rules.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.AW(31)) bus ();

    pc_sequencer #(.AW(31)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: m_mode 0 = boot, 1 = running, 2 = halted.
    logic [31:0] m_pc;
    logic [31:0] m_xp;
    int          m_mode;
    bit          m_pend;
    bit          m_taken;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_inc(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    task automatic model_reset();
        m_pc    = 32'h8000_0000;
        m_xp    = 32'h0;
        m_mode  = 0;
        m_pend  = 1'b0;
        m_taken = 1'b0;
    endtask

    task automatic model_update(input bit st, input bit hl, input bit rs,
                                input logic [1:0] sel, input logic [30:0] bt,
                                input logic [31:0] jt, input bit irq);
        logic [31:0] inc;
        bit          pend_n;
        inc     = m_inc(m_pc);
        m_taken = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            pend_n = m_pend | irq;
            if (!st) begin
                if (sel == 2'd3) begin
                    m_xp = inc;
                    m_pc = 32'h8000_0004;
                end else if (m_pend && !m_pc[31]) begin
                    m_xp    = inc;
                    m_pc    = 32'h8000_0008;
                    m_taken = 1'b1;
                    pend_n  = irq;
                end else if (sel == 2'd2) begin
                    m_pc = (m_pc & jt & 32'h8000_0000) | (jt & 32'h7FFF_FFFC);
                end else if (sel == 2'd1) begin
                    m_pc = (m_pc & 32'h8000_0000) | ({1'b0, bt} & 32'h7FFF_FFFC);
                end else begin
                    m_pc = inc;
                end
                if (hl) m_mode = 2;
            end
            m_pend = pend_n;
        end else begin
            m_pend = m_pend | irq;
            if (rs) m_mode = 1;
        end
    endtask

    task automatic check_all();
        chk("pc",       64'(bus.Pc),       64'(m_pc));
        chk("pcinc",    64'(bus.PcInc),    64'(m_inc(m_pc)));
        chk("pcvalid",  64'(bus.PcValid),  64'(m_mode == 1));
        chk("halted",   64'(bus.Halted),   64'(m_mode == 2));
        chk("irqtaken", 64'(bus.IrqTaken), 64'(m_taken));
        chk("xpvalue",  64'(bus.XpValue),  64'(m_xp));
    endtask

    task automatic step(input bit st, input bit hl, input bit rs,
                        input logic [1:0] sel, input logic [30:0] bt,
                        input logic [31:0] jt, input bit irq);
        bus.Stall        = st;
        bus.Halt         = hl;
        bus.Resume       = rs;
        bus.PcSel        = sel;
        bus.BranchTarget = bt;
        bus.JumpTarget   = jt;
        bus.IrqReq       = irq;
        model_update(st, hl, rs, sel, bt, jt, irq);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bus.Stall        = 1'b0;
        bus.Halt         = 1'b0;
        bus.Resume       = 1'b0;
        bus.PcSel        = 2'd0;
        bus.BranchTarget = '0;
        bus.JumpTarget   = '0;
        bus.IrqReq       = 1'b0;
        rst_n            = 1'b0;
        model_reset();
        #7;
        check_all();
        #5 rst_n = 1'b1;

        // Boot cycle then sequential fetch.
        step(0, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("seq_after_boot", 64'(bus.Pc), 64'h8000_0008);

        // Supervisor jump to user space, then user jump cannot raise privilege.
        step(0, 0, 0, 2'd2, '0, 32'h0000_0200, 0);
        chk("sup_jump", 64'(bus.Pc), 64'h0000_0200);
        step(0, 0, 0, 2'd2, '0, 32'h8000_1003, 0);
        chk("user_jump", 64'(bus.Pc), 64'h0000_1000);

        // Address wrap keeps supervisor bit clear.
        step(0, 0, 0, 2'd2, '0, 32'h7FFF_FFFC, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("wrap", 64'(bus.Pc), 64'h0);

        // Interrupt requested during a stall, taken on release.
        step(0, 0, 0, 2'd1, 31'h100, '0, 0);
        step(1, 0, 0, 2'd0, '0, '0, 1);
        step(1, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("irq_pc", 64'(bus.Pc), 64'h8000_0008);
        chk("irq_xp", 64'(bus.XpValue), 64'h104);
        chk("irq_pulse", 64'(bus.IrqTaken), 64'h1);
        step(0, 0, 0, 2'd0, '0, '0, 0);

        // Interrupt masked in supervisor mode until the jump to user.
        step(0, 0, 0, 2'd0, '0, '0, 1);
        step(0, 0, 0, 2'd2, '0, 32'h0000_0040, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("masked_irq_xp", 64'(bus.XpValue), 64'h44);

        // Illegal op beats pending interrupt; interrupt waits for user mode.
        step(0, 0, 0, 2'd0, '0, '0, 1);
        step(0, 0, 0, 2'd2, '0, 32'h0000_0040, 0);
        step(0, 0, 0, 2'd3, '0, '0, 0);
        chk("illop_pc", 64'(bus.Pc), 64'h8000_0004);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd2, '0, 32'h0000_0080, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("late_irq_xp", 64'(bus.XpValue), 64'h84);

        // Halt in user mode, interrupt arrives while halted, Resume wins over Halt.
        step(0, 0, 0, 2'd2, '0, 32'h0000_0300, 0);
        step(0, 1, 0, 2'd0, '0, '0, 0);
        for (int i = 0; i < 5; i++) step(i[0], i[1], 0, 2'd0, '0, '0, i == 2);
        chk("halt_pc", 64'(bus.Pc), 64'h304);
        step(0, 1, 1, 2'd0, '0, '0, 0);
        step(1, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("resume_irq_xp", 64'(bus.XpValue), 64'h308);

        // Asynchronous reset mid-operation drops a pending interrupt.
        step(0, 0, 0, 2'd2, '0, 32'h0000_0500, 0);
        step(1, 0, 0, 2'd0, '0, '0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        step(0, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd2, '0, 32'h0000_0500, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        step(0, 0, 0, 2'd0, '0, '0, 0);
        chk("reset_clears_irq", 64'(bus.Pc), 64'h508);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [1:0]  sel;
            r = $urandom_range(0, 15);
            if (r < 8)       sel = 2'd0;
            else if (r < 11) sel = 2'd1;
            else if (r < 15) sel = 2'd2;
            else             sel = 2'd3;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) == 0, sel, 31'($urandom), 32'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
